// File: rtl/rnn_readout.sv
// rnn_readout: scores each RNN timestep as bias + w.h over 64 hidden units,
// streaming one rounded Q16.16 result per timestep through a valid/ready port.
module rnn_readout (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] num_t,
    output logic        busy,
    output logic        done,
    output logic        mce,
    output logic [2:0]  msel,
    output logic [16:0] maddr,
    input  logic [19:0] mdata_r,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [31:0] y_data
);
    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, MAC, OUT} state_t;

    state_t state, state_n;
    logic [6:0]  k, k_n;
    logic [10:0] t, t_n, nt, nt_n;
    logic        done_n, ld_y;

    logic [19:0] w_rf [64];
    logic [19:0] bias;
    logic        d1_w, d1_b, d1_m, d2;
    logic [5:0]  d1_k;
    logic signed [39:0] prod;
    logic signed [45:0] acc;
    logic [45:0] rnd;

    assign busy    = state != IDLE;
    assign y_valid = state == OUT;
    assign rnd     = acc + 46'd32768;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            t     <= '0;
            nt    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            t     <= t_n;
            nt    <= nt_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        t_n     = t;
        nt_n    = nt;
        done_n  = 1'b0;
        ld_y    = 1'b0;
        mce     = 1'b0;
        msel    = 3'b000;
        maddr   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    nt_n = num_t;
                    t_n  = '0;
                    k_n  = '0;
                    if (num_t == 11'd0) done_n = 1'b1;
                    else state_n = LOAD_W;
                end
            end
            LOAD_W: begin
                mce   = 1'b1;
                msel  = 3'b110;
                maddr = {11'd0, k[5:0]};
                k_n   = k + 7'd1;
                if (k == 7'd63) begin
                    k_n     = '0;
                    state_n = LOAD_B;
                end
            end
            LOAD_B: begin
                mce     = 1'b1;
                msel    = 3'b111;
                k_n     = '0;
                state_n = MAC;
            end
            MAC: begin
                // k runs past 63 for three drain cycles while the pipeline empties
                if (k < 7'd64) begin
                    mce   = 1'b1;
                    msel  = 3'b101;
                    maddr = {t, k[5:0]};
                end
                k_n = k + 7'd1;
                if (k == 7'd66) begin
                    ld_y    = 1'b1;
                    state_n = OUT;
                end
            end
            OUT: begin
                if (y_ready) begin
                    t_n = t + 11'd1;
                    k_n = '0;
                    if ({1'b0, t} + 12'd1 < {1'b0, nt}) state_n = MAC;
                    else begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Weight file is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (d1_w) w_rf[d1_k] <= mdata_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1_w   <= 1'b0;
            d1_b   <= 1'b0;
            d1_m   <= 1'b0;
            d2     <= 1'b0;
            d1_k   <= '0;
            bias   <= '0;
            prod   <= '0;
            acc    <= '0;
            y_data <= '0;
        end else begin
            d1_w <= state == LOAD_W;
            d1_b <= state == LOAD_B;
            d1_m <= state == MAC && k < 7'd64;
            d2   <= d1_m;
            d1_k <= k[5:0];
            if (d1_b) bias <= mdata_r;
            if (d1_m) prod <= $signed(mdata_r) * $signed(w_rf[d1_k]);
            if (d1_m && d1_k == 6'd0) acc <= $signed({{10{bias[19]}}, bias, 16'd0});
            else if (d2) acc <= acc + {{6{prod[39]}}, prod};
            if (ld_y) y_data <= {{2{rnd[45]}}, rnd[45:16]};
        end
    end
endmodule

// File: tb/tb_rnn_readout.sv
// tb_rnn_readout: directed checks of rnn_readout against a behavioural memory
// and hand-computed scores, latencies and handshake behaviour.
module tb_rnn_readout;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] num_t = '0;
    logic        busy, done, mce, y_valid;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_r = '0;
    logic        y_ready = 1'b0;
    logic [31:0] y_data;

    logic [19:0] hmem [4][64];
    logic [19:0] wmem [64];
    logic [19:0] bmem;

    int checks = 0, errors = 0;
    int mce_cnt = 0, idle_bad = 0;
    int n, m0, cnt;
    logic [31:0] held;

    rnn_readout dut (
        .clk(clk), .reset(reset), .start(start), .num_t(num_t),
        .busy(busy), .done(done), .mce(mce), .msel(msel), .maddr(maddr),
        .mdata_r(mdata_r), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] rd(input logic [2:0] s, input logic [16:0] a);
        int ti;
        ti = int'(a[16:6]);
        if (s == 3'b101) return (ti < 4) ? hmem[ti][a[5:0]] : 20'h0;
        if (s == 3'b110) return wmem[a[5:0]];
        if (s == 3'b111) return bmem;
        return 20'h0;
    endfunction

    always @(posedge clk) begin
        if (mce) mce_cnt++;
        if (!mce && (msel != 3'b000 || maddr != 17'd0)) idle_bad++;
        mdata_r <= mce ? rd(msel, maddr) : 20'h0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int nt);
        num_t = 11'(nt);
        start = 1'b1;
        tick;
        start = 1'b0;
        num_t = '0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!y_valid && lat < 400) begin
            tick;
            lat++;
        end
    endtask

    task automatic handshake;
        y_ready = 1'b1;
        tick;
        y_ready = 1'b0;
    endtask

    task automatic fill(input logic [19:0] wv, input logic [19:0] hv, input logic [19:0] bv);
        for (int i = 0; i < 64; i++) begin
            wmem[i] = wv;
            for (int j = 0; j < 4; j++) hmem[j][i] = hv;
        end
        bmem = bv;
    endtask

    initial begin
        fill(20'h0, 20'h0, 20'h0);
        tick;
        tick;
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mce", {31'd0, mce}, 32'd0);
        chk("rst_yvalid", {31'd0, y_valid}, 32'd0);
        chk("rst_ydata", y_data, 32'd0);
        chk("rst_bus", {12'd0, msel, maddr}, 32'd0);

        // unit weights and hidden state: 64 * 1.0
        fill(20'h10000, 20'h10000, 20'h0);
        m0 = mce_cnt;
        start_job(1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_valid(n);
        chk("first_latency", n, 133);
        chk("y_unit", y_data, 32'h00400000);
        chk("mce_reads_1", mce_cnt - m0, 129);
        chk("mce_zero_in_out", {31'd0, mce}, 32'd0);
        handshake;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_cleared", {31'd0, busy}, 32'd0);
        chk("yvalid_cleared", {31'd0, y_valid}, 32'd0);
        tick;
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // negative hidden state plus half bias
        fill(20'h10000, 20'hF0000, 20'h08000);
        start_job(1);
        wait_valid(n);
        chk("neg_latency", n, 133);
        chk("y_neg_bias", y_data, 32'hFFC08000);
        handshake;
        tick;

        // rounding at exactly one half LSB rounds up
        fill(20'h0, 20'h0, 20'h0);
        wmem[0] = 20'h00001;
        hmem[0][0] = 20'h08000;
        start_job(1);
        wait_valid(n);
        chk("round_half_up", y_data, 32'h00000001);
        handshake;
        tick;
        hmem[0][0] = 20'h07FFF;
        start_job(1);
        wait_valid(n);
        chk("round_below_half", y_data, 32'h00000000);
        handshake;
        tick;

        // three timesteps with a stall on t=1
        fill(20'h10000, 20'h0, 20'h0);
        for (int i = 0; i < 64; i++) begin
            hmem[0][i] = 20'h10000;
            hmem[1][i] = 20'h20000;
            hmem[2][i] = 20'hF0000;
        end
        m0 = mce_cnt;
        start_job(3);
        wait_valid(n);
        chk("t0_latency", n, 133);
        chk("t0_y", y_data, 32'h00400000);
        handshake;
        chk("t0_no_done", {31'd0, done}, 32'd0);
        wait_valid(n);
        chk("t1_latency", n, 68);
        chk("t1_y", y_data, 32'h00800000);
        held = y_data;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            tick;
            if (!y_valid || y_data !== held || mce || done) cnt++;
        end
        start = 1'b0;
        chk("stall_stable", cnt, 0);
        handshake;
        wait_valid(n);
        chk("t2_latency", n, 68);
        chk("t2_y", y_data, 32'hFFC00000);
        chk("mce_reads_3", mce_cnt - m0, 257);
        handshake;
        chk("done_after_t2", {31'd0, done}, 32'd1);
        tick;

        // zero timesteps: immediate done, no memory traffic
        m0 = mce_cnt;
        start_job(0);
        chk("nt0_done", {31'd0, done}, 32'd1);
        chk("nt0_busy", {31'd0, busy}, 32'd0);
        tick;
        chk("nt0_done_clear", {31'd0, done}, 32'd0);
        chk("nt0_no_reads", mce_cnt - m0, 0);

        // reset in the middle of MAC abandons the job
        fill(20'h10000, 20'h10000, 20'h0);
        start_job(1);
        for (int i = 0; i < 80; i++) tick;
        chk("mid_mac_reading", {31'd0, mce}, 32'd1);
        reset = 1'b1;
        tick;
        chk("mid_rst_out", {busy, done, mce, y_valid, 12'd0, msel, maddr}, 32'd0);
        chk("mid_rst_ydata", y_data, 32'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick;
            if (y_valid || done || busy) cnt++;
        end
        chk("abandoned_quiet", cnt, 0);
        start_job(1);
        wait_valid(n);
        chk("restart_latency", n, 133);
        chk("restart_y", y_data, 32'h00400000);
        handshake;
        chk("restart_done", {31'd0, done}, 32'd1);
        tick;

        chk("bus_zero_when_idle", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
